// File: rtl/seletor_clock_multimodo_pkg.sv
// Shared definitions for the multi-mode processor clock selector:
// mode encodings applied through MODO / MODO_ATUAL.
package seletor_clock_multimodo_pkg;

    typedef logic [1:0] modo_t;

    localparam modo_t MODO_LIVRE  = 2'b00;
    localparam modo_t MODO_MANUAL = 2'b01;
    localparam modo_t MODO_PASSO  = 2'b10;
    localparam modo_t MODO_PARADO = 2'b11;

endpackage

// File: rtl/seletor_clock_multimodo_if.sv
// Control/status bundle between the board side (buttons, mode select)
// and the clock selector that feeds the core.
interface seletor_clock_multimodo_if #(
    parameter int LARGURA_DIV    = 24,
    parameter int LARGURA_PASSOS = 8
);
    logic                      CLKManual;
    logic [1:0]                MODO;
    logic [LARGURA_DIV-1:0]    DIVISOR;
    logic [LARGURA_PASSOS-1:0] PASSOS;
    logic                      CLK;
    logic                      CLKEN;
    logic                      OCUPADO;
    logic [1:0]                MODO_ATUAL;

    modport master (
        output CLKManual, MODO, DIVISOR, PASSOS,
        input  CLK, CLKEN, OCUPADO, MODO_ATUAL
    );

    modport slave (
        input  CLKManual, MODO, DIVISOR, PASSOS,
        output CLK, CLKEN, OCUPADO, MODO_ATUAL
    );
endinterface

// File: rtl/seletor_clock_multimodo_debounce_botao.sv
// Push-button conditioning: 2-FF synchronizer, debounce counter and a
// one-cycle pulse on each accepted 0->1 transition.
module debounce_botao #(
    parameter int LARGURA_DEB     = 20,
    parameter int DEBOUNCE_CICLOS = 500000
) (
    input  logic CLKFPGA,
    input  logic RST,
    input  logic ENTRADA,
    output logic NIVEL,
    output logic BORDA_SUBIDA
);
    localparam logic [LARGURA_DEB-1:0] LIMITE = LARGURA_DEB'(DEBOUNCE_CICLOS - 1);

    logic [1:0]             sinc_q, sinc_d;
    logic [LARGURA_DEB-1:0] cont_q, cont_d;
    logic                   nivel_q, nivel_d;
    logic                   borda_q, borda_d;

    // The counter only runs while the synchronized input disagrees with the
    // accepted level, so any bounce back to the old level restarts it.
    always_comb begin
        sinc_d  = {sinc_q[0], ENTRADA};
        nivel_d = nivel_q;
        cont_d  = '0;
        if (sinc_q[1] != nivel_q) begin
            if (cont_q == LIMITE) begin
                nivel_d = sinc_q[1];
            end else begin
                cont_d = cont_q + 1'b1;
            end
        end
        borda_d = nivel_d & ~nivel_q;
    end

    always_ff @(posedge CLKFPGA) begin
        if (RST) begin
            sinc_q  <= '0;
            cont_q  <= '0;
            nivel_q <= 1'b0;
            borda_q <= 1'b0;
        end else begin
            sinc_q  <= sinc_d;
            cont_q  <= cont_d;
            nivel_q <= nivel_d;
            borda_q <= borda_d;
        end
    end

    assign NIVEL        = nivel_q;
    assign BORDA_SUBIDA = borda_q;
endmodule

// File: rtl/seletor_clock_multimodo.sv
// Multi-mode processor clock generator (livre / manual / passo / parado)
// with a registered, glitch-free CLK and a one-cycle CLKEN strobe.
module seletor_clock_multimodo
    import seletor_clock_multimodo_pkg::*;
#(
    parameter int LARGURA_DIV     = 24,
    parameter int LARGURA_DEB     = 20,
    parameter int DEBOUNCE_CICLOS = 500000,
    parameter int LARGURA_PASSOS  = 8
) (
    input  logic                        CLKFPGA,
    input  logic                        RST,
    seletor_clock_multimodo_if.slave    bus
);
    logic                      nivel, borda;
    modo_t                     modo_q, modo_d;
    logic                      clk_q, clk_d;
    logic                      clken_q, clken_d;
    logic                      ocupado_q, ocupado_d;
    logic [LARGURA_DIV-1:0]    div_q, div_d;
    logic [LARGURA_PASSOS-1:0] passos_q, passos_d;
    logic                      troca, gira, estouro;

    debounce_botao #(
        .LARGURA_DEB     (LARGURA_DEB),
        .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS)
    ) u_debounce (
        .CLKFPGA      (CLKFPGA),
        .RST          (RST),
        .ENTRADA      (bus.CLKManual),
        .NIVEL        (nivel),
        .BORDA_SUBIDA (borda)
    );

    always_comb begin
        modo_d = modo_q;
        if (!clk_q && !ocupado_q) begin
            modo_d = bus.MODO;
        end
        troca   = (modo_d != modo_q);
        gira    = (modo_q == MODO_LIVRE) || ocupado_q;
        estouro = (div_q >= bus.DIVISOR);

        div_d     = '0;
        clk_d     = 1'b0;
        ocupado_d = ocupado_q;
        passos_d  = passos_q;

        if (gira) begin
            if (estouro) begin
                clk_d = ~clk_q;
            end else begin
                clk_d = clk_q;
                div_d = div_q + 1'b1;
            end
        end else if (modo_q == MODO_MANUAL) begin
            clk_d = nivel;
        end

        // A mode change only happens with CLK low; hold it there for the
        // switching cycle so the new mode starts from a clean low phase.
        if (troca) begin
            clk_d = clk_q;
            div_d = '0;
        end

        if (ocupado_q) begin
            if (clk_d && !clk_q) begin
                passos_d = passos_q - 1'b1;
            end
            if (!clk_d && clk_q && (passos_q == '0)) begin
                ocupado_d = 1'b0;
            end
        end else if ((modo_q == MODO_PASSO) && borda && (bus.PASSOS != '0)) begin
            ocupado_d = 1'b1;
            passos_d  = bus.PASSOS;
            div_d     = '0;
        end

        clken_d = clk_d & ~clk_q;
    end

    always_ff @(posedge CLKFPGA) begin
        if (RST) begin
            modo_q    <= MODO_LIVRE;
            clk_q     <= 1'b0;
            clken_q   <= 1'b0;
            ocupado_q <= 1'b0;
            div_q     <= '0;
            passos_q  <= '0;
        end else begin
            modo_q    <= modo_d;
            clk_q     <= clk_d;
            clken_q   <= clken_d;
            ocupado_q <= ocupado_d;
            div_q     <= div_d;
            passos_q  <= passos_d;
        end
    end

    assign bus.CLK        = clk_q;
    assign bus.CLKEN      = clken_q;
    assign bus.OCUPADO    = ocupado_q;
    assign bus.MODO_ATUAL = modo_q;
endmodule
